// File: rtl/hazard_scoreboard_if.sv
// hazard_scoreboard_if: decode <-> scoreboard handshake bundle.
//   dec_*         : instruction currently held in decode (driven by decode, master)
//   issue         : instruction issues this cycle (driven by scoreboard, slave)
//   stall_decode  : hold decode
//   stall_fetch   : hold fetch (identical to stall_decode)
//   stall_reason  : {rob, raw, waw, wb_struct}
interface hazard_scoreboard_if #(
    parameter int unsigned REGISTER_WIDTH = 5
);
    logic                      dec_valid;
    logic [1:0]                dec_unit;
    logic [REGISTER_WIDTH-1:0] dec_rs1;
    logic [REGISTER_WIDTH-1:0] dec_rs2;
    logic                      dec_rs1_needed;
    logic                      dec_rs2_needed;
    logic [REGISTER_WIDTH-1:0] dec_rd;
    logic                      dec_rd_wr_en;
    logic                      issue;
    logic                      stall_decode;
    logic                      stall_fetch;
    logic [3:0]                stall_reason;

    modport master (
        output dec_valid, dec_unit, dec_rs1, dec_rs2, dec_rs1_needed, dec_rs2_needed,
        output dec_rd, dec_rd_wr_en,
        input  issue, stall_decode, stall_fetch, stall_reason
    );

    modport slave (
        input  dec_valid, dec_unit, dec_rs1, dec_rs2, dec_rs1_needed, dec_rs2_needed,
        input  dec_rd, dec_rd_wr_en,
        output issue, stall_decode, stall_fetch, stall_reason
    );
endinterface

// File: rtl/hazard_scoreboard.sv
// hazard_scoreboard: registered issue scoreboard beside decode.
// Tracks per-register pending bit, producer unit tag and remaining fixed latency, plus a
// writeback-port reservation table, and decides issue/stall for ALU, MUL and MEM ops.
// Ports:
//   clk_i, rst_i        : clock, synchronous active-high reset
//   dec_if (slave)      : decode instruction in, issue/stall/stall_reason out
//   rob_is_full_i       : ROB cannot accept
//   freeze_i            : backend frozen (state holds except MEM writeback clears)
//   flush_i             : clear all scoreboard state, suppress issue
//   mem_wb_valid_i/reg_i: MEM writeback this cycle
//   pending_count_o     : registered popcount of pending registers
module hazard_scoreboard #(
    parameter int unsigned REGISTER_WIDTH = 5,
    parameter int unsigned ALU_LATENCY    = 1,
    parameter int unsigned MUL_LATENCY    = 5,
    parameter int unsigned NUM_WB_PORTS   = 1,
    parameter bit          BYPASS_EN      = 1'b1
) (
    input  logic                      clk_i,
    input  logic                      rst_i,
    hazard_scoreboard_if.slave        dec_if,
    input  logic                      rob_is_full_i,
    input  logic                      freeze_i,
    input  logic                      flush_i,
    input  logic                      mem_wb_valid_i,
    input  logic [REGISTER_WIDTH-1:0] mem_wb_reg_i,
    output logic [REGISTER_WIDTH:0]   pending_count_o
);
    localparam int unsigned NUM_REGS   = 2 ** REGISTER_WIDTH;
    localparam int unsigned CNT_W      = $clog2(MUL_LATENCY + 1);
    localparam int unsigned RESV_DEPTH = MUL_LATENCY + 1;
    localparam int unsigned SLOT_W     = $clog2(RESV_DEPTH);
    localparam int unsigned RESV_W     = $clog2(NUM_WB_PORTS + 1);

    localparam logic [CNT_W-1:0]  CntOne   = CNT_W'(1);
    localparam logic [CNT_W-1:0]  AluLat   = CNT_W'(ALU_LATENCY);
    localparam logic [CNT_W-1:0]  MulLat   = CNT_W'(MUL_LATENCY);
    localparam logic [SLOT_W-1:0] AluSlot  = SLOT_W'(ALU_LATENCY);
    localparam logic [SLOT_W-1:0] MulSlot  = SLOT_W'(MUL_LATENCY);
    // Booking lands one slot lower because the table shifts on the same edge.
    localparam logic [SLOT_W-1:0] AluBook  = SLOT_W'(ALU_LATENCY - 1);
    localparam logic [SLOT_W-1:0] MulBook  = SLOT_W'(MUL_LATENCY - 1);
    localparam logic [RESV_W-1:0] NumPorts = RESV_W'(NUM_WB_PORTS);

    typedef enum logic [1:0] {UnitAlu = 2'd0, UnitMul = 2'd1, UnitMem = 2'd2, UnitNone = 2'd3} unit_e;

    logic [NUM_REGS-1:0]                 pending_q, pending_d;
    unit_e [NUM_REGS-1:0]                tag_q, tag_d;
    logic [NUM_REGS-1:0][CNT_W-1:0]      cnt_q, cnt_d;
    logic [RESV_DEPTH-1:0][RESV_W-1:0]   resv_q, resv_d;
    logic [REGISTER_WIDTH:0]             count_q, count_d;

    logic [NUM_REGS-1:0] src_ready;
    unit_e               unit;
    logic                is_fixed, rd_write, slot_full;
    logic [CNT_W-1:0]    lat;
    logic [SLOT_W-1:0]   book_slot;
    logic                raw, waw, wb_struct, stall, issue;

    // Hazard evaluation
    always_comb begin
        for (int r = 0; r < NUM_REGS; r++) begin
            src_ready[r] = !pending_q[r] ||
                (BYPASS_EN && tag_q[r] != UnitMem && cnt_q[r] == CntOne) ||
                (BYPASS_EN && tag_q[r] == UnitMem && mem_wb_valid_i &&
                 mem_wb_reg_i == REGISTER_WIDTH'(r));
        end
        unit      = unit_e'(dec_if.dec_unit);
        is_fixed  = (unit == UnitAlu) || (unit == UnitMul);
        rd_write  = dec_if.dec_rd_wr_en && (unit != UnitNone) && (dec_if.dec_rd != '0);
        // A MEM op has no fixed latency, so any pending producer of rd is a WAW hazard.
        lat       = (unit == UnitMul) ? MulLat : (unit == UnitAlu) ? AluLat : CntOne;
        book_slot = (unit == UnitMul) ? MulBook : AluBook;
        slot_full = (unit == UnitMul) ? (resv_q[MulSlot] == NumPorts)
                                      : (resv_q[AluSlot] == NumPorts);
        raw       = (dec_if.dec_rs1_needed && !src_ready[dec_if.dec_rs1]) ||
                    (dec_if.dec_rs2_needed && !src_ready[dec_if.dec_rs2]);
        waw       = rd_write && pending_q[dec_if.dec_rd] &&
                    (tag_q[dec_if.dec_rd] == UnitMem || cnt_q[dec_if.dec_rd] >= lat);
        wb_struct = is_fixed && rd_write && slot_full;
        stall     = dec_if.dec_valid && (rob_is_full_i || raw || waw || wb_struct || freeze_i);
        issue     = dec_if.dec_valid && !stall && !flush_i;
    end

    assign dec_if.issue        = issue;
    assign dec_if.stall_decode = stall;
    assign dec_if.stall_fetch  = stall;
    assign dec_if.stall_reason = {rob_is_full_i, raw, waw, wb_struct};
    assign pending_count_o     = count_q;

    // Next state
    always_comb begin
        pending_d = pending_q;
        tag_d     = tag_q;
        cnt_d     = cnt_q;
        resv_d    = resv_q;
        count_d   = '0;
        if (!freeze_i) begin
            for (int r = 0; r < NUM_REGS; r++) begin
                if (pending_q[r] && tag_q[r] != UnitMem) begin
                    if (cnt_q[r] == CntOne) begin
                        pending_d[r] = 1'b0;
                        cnt_d[r]     = '0;
                    end else begin
                        cnt_d[r] = cnt_q[r] - CntOne;
                    end
                end
            end
            for (int k = 0; k < RESV_DEPTH - 1; k++) begin
                resv_d[k] = resv_q[k+1];
            end
            resv_d[RESV_DEPTH-1] = '0;
        end
        // MEM completions still retire while frozen.
        if (mem_wb_valid_i && pending_q[mem_wb_reg_i] && tag_q[mem_wb_reg_i] == UnitMem) begin
            pending_d[mem_wb_reg_i] = 1'b0;
        end
        // Issue is applied last so a new producer wins over a same-edge clear.
        if (issue && rd_write) begin
            pending_d[dec_if.dec_rd] = 1'b1;
            tag_d[dec_if.dec_rd]     = unit;
            if (is_fixed) begin
                cnt_d[dec_if.dec_rd] = lat;
                resv_d[book_slot]    = resv_d[book_slot] + RESV_W'(1);
            end else begin
                cnt_d[dec_if.dec_rd] = '0;
            end
        end
        if (flush_i) begin
            pending_d = '0;
            tag_d     = '{default: UnitAlu};
            cnt_d     = '0;
            resv_d    = '0;
        end
        pending_d[0] = 1'b0;
        for (int r = 0; r < NUM_REGS; r++) begin
            count_d = count_d + (REGISTER_WIDTH + 1)'(pending_d[r]);
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            pending_q <= '0;
            tag_q     <= '{default: UnitAlu};
            cnt_q     <= '0;
            resv_q    <= '0;
            count_q   <= '0;
        end else begin
            pending_q <= pending_d;
            tag_q     <= tag_d;
            cnt_q     <= cnt_d;
            resv_q    <= resv_d;
            count_q   <= count_d;
        end
    end
endmodule

// File: tb/tb_hazard_scoreboard.sv
// Directed bench for hazard_scoreboard: one DUT with bypass, one without, same stimulus.
module tb_hazard_scoreboard;
    localparam int unsigned RW = 5;
    localparam logic [1:0] UAlu = 2'd0, UMul = 2'd1, UMem = 2'd2, UNone = 2'd3;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic          rst, rob, freeze, flush, mem_wb_valid;
    logic [RW-1:0] mem_wb_reg;
    logic [RW:0]   cnt_a, cnt_b;

    logic          d_valid, d_n1, d_n2, d_wr;
    logic [1:0]    d_unit;
    logic [RW-1:0] d_rs1, d_rs2, d_rd;

    int n_checks = 0;
    int n_errors = 0;

    hazard_scoreboard_if #(.REGISTER_WIDTH(RW)) if_a ();
    hazard_scoreboard_if #(.REGISTER_WIDTH(RW)) if_b ();

    assign if_a.dec_valid = d_valid;      assign if_b.dec_valid = d_valid;
    assign if_a.dec_unit = d_unit;        assign if_b.dec_unit = d_unit;
    assign if_a.dec_rs1 = d_rs1;          assign if_b.dec_rs1 = d_rs1;
    assign if_a.dec_rs2 = d_rs2;          assign if_b.dec_rs2 = d_rs2;
    assign if_a.dec_rs1_needed = d_n1;    assign if_b.dec_rs1_needed = d_n1;
    assign if_a.dec_rs2_needed = d_n2;    assign if_b.dec_rs2_needed = d_n2;
    assign if_a.dec_rd = d_rd;            assign if_b.dec_rd = d_rd;
    assign if_a.dec_rd_wr_en = d_wr;      assign if_b.dec_rd_wr_en = d_wr;

    hazard_scoreboard #(
        .REGISTER_WIDTH(RW), .ALU_LATENCY(1), .MUL_LATENCY(5), .NUM_WB_PORTS(1), .BYPASS_EN(1'b1)
    ) u_dut_a (
        .clk_i(clk), .rst_i(rst), .dec_if(if_a.slave), .rob_is_full_i(rob), .freeze_i(freeze),
        .flush_i(flush), .mem_wb_valid_i(mem_wb_valid), .mem_wb_reg_i(mem_wb_reg),
        .pending_count_o(cnt_a)
    );

    hazard_scoreboard #(
        .REGISTER_WIDTH(RW), .ALU_LATENCY(1), .MUL_LATENCY(5), .NUM_WB_PORTS(1), .BYPASS_EN(1'b0)
    ) u_dut_b (
        .clk_i(clk), .rst_i(rst), .dec_if(if_b.slave), .rob_is_full_i(rob), .freeze_i(freeze),
        .flush_i(flush), .mem_wb_valid_i(mem_wb_valid), .mem_wb_reg_i(mem_wb_reg),
        .pending_count_o(cnt_b)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic v, input logic [1:0] u, input logic [RW-1:0] r1,
                         input logic n1, input logic [RW-1:0] r2, input logic n2,
                         input logic [RW-1:0] rd, input logic wr);
        d_valid = v; d_unit = u; d_rs1 = r1; d_n1 = n1; d_rs2 = r2; d_n2 = n2;
        d_rd = rd; d_wr = wr;
        #1;
    endtask

    task automatic idle();
        drive(1'b0, UNone, 5'd0, 1'b0, 5'd0, 1'b0, 5'd0, 1'b0);
    endtask

    initial begin
        rst = 1'b1; rob = 1'b0; freeze = 1'b0; flush = 1'b0;
        mem_wb_valid = 1'b0; mem_wb_reg = '0;
        idle();
        tick(); tick();
        rst = 1'b0;

        // Reset state, then ROB-full only
        drive(1'b1, UNone, 5'd0, 1'b0, 5'd0, 1'b0, 5'd0, 1'b0);
        check("rst_issue", 32'(if_a.issue), 32'd1);
        check("rst_reason", 32'(if_a.stall_reason), 32'd0);
        check("rst_count", 32'(cnt_a), 32'd0);
        rob = 1'b1; #1;
        check("rob_issue", 32'(if_a.issue), 32'd0);
        check("rob_reason", 32'(if_a.stall_reason), 32'h8);
        check("rob_stall_fetch", 32'(if_a.stall_fetch), 32'd1);
        rob = 1'b0;

        // ALU x5 then dependent: bypass vs no bypass
        tick(); drive(1'b1, UAlu, 5'd0, 1'b0, 5'd0, 1'b0, 5'd5, 1'b1);
        check("alu_issue_a", 32'(if_a.issue), 32'd1);
        check("alu_issue_b", 32'(if_b.issue), 32'd1);
        tick(); drive(1'b1, UAlu, 5'd5, 1'b1, 5'd0, 1'b0, 5'd0, 1'b0);
        check("byp_issue_a", 32'(if_a.issue), 32'd1);
        check("nobyp_issue_b_t1", 32'(if_b.issue), 32'd0);
        check("nobyp_reason_b_t1", 32'(if_b.stall_reason), 32'h4);
        tick();
        check("nobyp_issue_b_t2", 32'(if_b.issue), 32'd1);
        tick(); idle();

        // MUL x7 then ALU reader
        tick(); drive(1'b1, UMul, 5'd0, 1'b0, 5'd0, 1'b0, 5'd7, 1'b1);
        check("mul_issue", 32'(if_a.issue), 32'd1);
        for (int i = 1; i <= 4; i++) begin
            tick(); drive(1'b1, UAlu, 5'd7, 1'b1, 5'd0, 1'b0, 5'd0, 1'b0);
            check($sformatf("mul_raw_issue_t%0d", i), 32'(if_a.issue), 32'd0);
            check($sformatf("mul_raw_reason_t%0d", i), 32'(if_a.stall_reason), 32'h4);
            check($sformatf("mul_raw_count_t%0d", i), 32'(cnt_a), 32'd1);
        end
        tick();
        check("mul_raw_issue_t5", 32'(if_a.issue), 32'd1);
        check("mul_raw_count_t5", 32'(cnt_a), 32'd1);
        tick(); idle();
        check("mul_raw_count_t6", 32'(cnt_a), 32'd0);

        // WAW: MUL x3 then ALU writing x3 (t4 also collides on the writeback slot)
        tick(); drive(1'b1, UMul, 5'd0, 1'b0, 5'd0, 1'b0, 5'd3, 1'b1);
        check("waw_mul_issue", 32'(if_a.issue), 32'd1);
        for (int i = 1; i <= 5; i++) begin
            tick(); drive(1'b1, UAlu, 5'd0, 1'b0, 5'd0, 1'b0, 5'd3, 1'b1);
            check($sformatf("waw_issue_t%0d", i), 32'(if_a.issue), 32'd0);
            check($sformatf("waw_reason_t%0d", i), 32'(if_a.stall_reason),
                  (i == 4) ? 32'h3 : 32'h2);
        end
        tick();
        check("waw_issue_t6", 32'(if_a.issue), 32'd1);
        tick(); idle();
        tick(); idle();

        // Writeback port conflict: MUL x4 at t0, ALU x6 at t4
        tick(); drive(1'b1, UMul, 5'd0, 1'b0, 5'd0, 1'b0, 5'd4, 1'b1);
        check("wb_mul_issue", 32'(if_a.issue), 32'd1);
        for (int i = 1; i <= 3; i++) begin
            tick(); idle();
        end
        tick(); drive(1'b1, UAlu, 5'd0, 1'b0, 5'd0, 1'b0, 5'd6, 1'b1);
        check("wb_issue_t4", 32'(if_a.issue), 32'd0);
        check("wb_reason_t4", 32'(if_a.stall_reason), 32'h1);
        tick();
        check("wb_issue_t5", 32'(if_a.issue), 32'd1);
        check("wb_reason_t5", 32'(if_a.stall_reason), 32'h0);
        tick(); idle();
        tick(); idle();
        check("wb_count_drained", 32'(cnt_a), 32'd0);

        // MEM load x9, consumer waits for writeback and bypasses
        tick(); drive(1'b1, UMem, 5'd0, 1'b0, 5'd0, 1'b0, 5'd9, 1'b1);
        check("mem_issue", 32'(if_a.issue), 32'd1);
        for (int i = 1; i <= 2; i++) begin
            tick(); drive(1'b1, UAlu, 5'd0, 1'b0, 5'd9, 1'b1, 5'd0, 1'b0);
            check($sformatf("mem_raw_issue_t%0d", i), 32'(if_a.issue), 32'd0);
            check($sformatf("mem_raw_reason_t%0d", i), 32'(if_a.stall_reason), 32'h4);
        end
        tick(); mem_wb_valid = 1'b1; mem_wb_reg = 5'd9; #1;
        check("mem_wb_issue", 32'(if_a.issue), 32'd1);
        tick(); mem_wb_valid = 1'b0; mem_wb_reg = '0; idle();
        check("mem_count_after_wb", 32'(cnt_a), 32'd0);

        // MEM load x9 squashed by flush
        tick(); drive(1'b1, UMem, 5'd0, 1'b0, 5'd0, 1'b0, 5'd9, 1'b1);
        tick(); drive(1'b1, UAlu, 5'd0, 1'b0, 5'd9, 1'b1, 5'd0, 1'b0);
        check("flush_pre_issue", 32'(if_a.issue), 32'd0);
        check("flush_pre_count", 32'(cnt_a), 32'd1);
        tick(); flush = 1'b1; drive(1'b1, UAlu, 5'd0, 1'b0, 5'd0, 1'b0, 5'd0, 1'b0);
        check("flush_suppress_issue", 32'(if_a.issue), 32'd0);
        tick(); flush = 1'b0; drive(1'b1, UAlu, 5'd0, 1'b0, 5'd9, 1'b1, 5'd0, 1'b0);
        check("flush_count", 32'(cnt_a), 32'd0);
        check("flush_consumer_issue", 32'(if_a.issue), 32'd1);

        // Freeze holds the MUL counter for two cycles
        tick(); drive(1'b1, UMul, 5'd0, 1'b0, 5'd0, 1'b0, 5'd7, 1'b1);
        check("frz_mul_issue", 32'(if_a.issue), 32'd1);
        for (int i = 1; i <= 6; i++) begin
            tick(); freeze = (i <= 2);
            drive(1'b1, UAlu, 5'd7, 1'b1, 5'd0, 1'b0, 5'd0, 1'b0);
            check($sformatf("frz_issue_t%0d", i), 32'(if_a.issue), 32'd0);
        end
        tick();
        check("frz_issue_t7", 32'(if_a.issue), 32'd1);
        tick(); idle();

        // MEM writeback clears even while frozen
        tick(); drive(1'b1, UMem, 5'd0, 1'b0, 5'd0, 1'b0, 5'd10, 1'b1);
        tick(); freeze = 1'b1; mem_wb_valid = 1'b1; mem_wb_reg = 5'd10; idle();
        check("frz_mem_count", 32'(cnt_a), 32'd1);
        tick(); freeze = 1'b0; mem_wb_valid = 1'b0; mem_wb_reg = '0; #1;
        check("frz_mem_cleared", 32'(cnt_a), 32'd0);

        // Three pending MEM loads, then reset
        for (int i = 0; i < 3; i++) begin
            tick(); drive(1'b1, UMem, 5'd0, 1'b0, 5'd0, 1'b0, RW'(10 + i), 1'b1);
            check($sformatf("rst_mem_issue_%0d", i), 32'(if_a.issue), 32'd1);
        end
        tick(); idle();
        check("rst_pre_count", 32'(cnt_a), 32'd3);
        rst = 1'b1;
        tick(); rst = 1'b0; #1;
        check("rst_post_count_a", 32'(cnt_a), 32'd0);
        check("rst_post_count_b", 32'(cnt_b), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end
endmodule
